// File: rtl/knap_pkg.sv
// Shared types for the knapsack Gray-code search: FSM state encoding,
// per-item coefficient record, and a constant-time clog2 helper.
// Ports: none (package).
package knap_pkg;

  localparam int KNAP_COEF_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } knap_state_e;

  typedef struct packed {
    logic [KNAP_COEF_W-1:0] val;
    logic [KNAP_COEF_W-1:0] wgt;
    logic [KNAP_COEF_W-1:0] vol;
  } item_coef_t;

  // Never returns less than 1 so index ports stay at least one bit wide.
  function automatic int knap_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/knap_flip_idx.sv
// Gray-code flip index: position of the lowest set bit of k+1 (ctz).
// Ports: kp1_i = k+1 (never zero while advancing), idx_o = bit to flip.
// Purely combinational, zero latency.
module knap_flip_idx
  import knap_pkg::*;
#(
  parameter int N     = 25,
  parameter int IDX_W = knap_clog2(N)
) (
  input  logic [N-1:0]     kp1_i,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (kp1_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/knap_gray_search.sv
// Multi-constraint 0/1 knapsack candidate generator: walks all selections in
// Gray-code order (one item flips per cycle), streams feasible ones on a
// valid/ready port, and reports best selection and solution count at the end.
// Ports: item_* table write (IDLE only), start_i/abort_i control, sol_* stream,
// busy_o/done_o status, best_*/sol_count_o results.
module knap_gray_search
  import knap_pkg::*;
#(
  parameter int N_ITEMS    = 25,
  parameter int COEF_W     = KNAP_COEF_W,
  parameter int ACC_W      = 10,
  parameter int MIN_VALUE  = 120,
  parameter int MAX_WEIGHT = 60,
  parameter int MAX_VOLUME = 60,
  localparam int IDX_W     = knap_clog2(N_ITEMS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               item_wr_i,
  input  logic [IDX_W-1:0]   item_idx_i,
  input  logic [COEF_W-1:0]  item_val_i,
  input  logic [COEF_W-1:0]  item_wgt_i,
  input  logic [COEF_W-1:0]  item_vol_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               sol_valid_o,
  input  logic               sol_ready_i,
  output logic [N_ITEMS-1:0] sol_sel_o,
  output logic [ACC_W-1:0]   sol_value_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_ITEMS-1:0] best_sel_o,
  output logic [ACC_W-1:0]   best_value_o,
  output logic [N_ITEMS:0]   sol_count_o
);

  if (N_ITEMS * ((1 << COEF_W) - 1) >= (1 << ACC_W)) begin : g_acc_too_narrow
    $error("ACC_W cannot hold the largest possible total");
  end
  if (COEF_W != KNAP_COEF_W) begin : g_coef_w_mismatch
    $error("COEF_W must match the package coefficient width");
  end

  localparam logic [ACC_W-1:0]   MIN_V   = ACC_W'(MIN_VALUE);
  localparam logic [ACC_W-1:0]   MAX_W   = ACC_W'(MAX_WEIGHT);
  localparam logic [ACC_W-1:0]   MAX_U   = ACC_W'(MAX_VOLUME);
  localparam logic [N_ITEMS-1:0] K_ONE   = N_ITEMS'(1);
  localparam logic [N_ITEMS:0]   CNT_ONE = (N_ITEMS + 1)'(1);

  item_coef_t table_q [N_ITEMS];

  knap_state_e        state_q, state_d;
  logic [N_ITEMS-1:0] k_q, k_d, sel_q, sel_d;
  logic [ACC_W-1:0]   tv_q, tv_d, tw_q, tw_d, tu_q, tu_d;
  logic               sol_valid_q, sol_valid_d;
  logic [N_ITEMS-1:0] sol_sel_q, sol_sel_d, best_sel_q, best_sel_d;
  logic [ACC_W-1:0]   sol_value_q, sol_value_d, best_value_q, best_value_d;
  logic [N_ITEMS:0]   sol_count_q, sol_count_d;

  logic               feas, stall, rising;
  logic [N_ITEMS-1:0] kp1;
  logic [IDX_W-1:0]   flip_j;
  item_coef_t         coef;

  knap_flip_idx #(.N(N_ITEMS), .IDX_W(IDX_W)) u_flip (
    .kp1_i (kp1),
    .idx_o (flip_j)
  );

  assign kp1    = k_q + K_ONE;
  assign coef   = table_q[flip_j];
  assign rising = ~sel_q[flip_j];
  assign feas   = (tv_q >= MIN_V) && (tw_q <= MAX_W) && (tu_q <= MAX_U);
  // Only a feasible candidate needs the output slot, so only it can stall.
  assign stall  = feas && sol_valid_q && !sol_ready_i;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    sel_d        = sel_q;
    tv_d         = tv_q;
    tw_d         = tw_q;
    tu_d         = tu_q;
    sol_valid_d  = sol_valid_q;
    sol_sel_d    = sol_sel_q;
    sol_value_d  = sol_value_q;
    best_sel_d   = best_sel_q;
    best_value_d = best_value_q;
    sol_count_d  = sol_count_q;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (feas) begin
            sol_valid_d = 1'b1;
            sol_sel_d   = sel_q;
            sol_value_d = tv_q;
            sol_count_d = sol_count_q + CNT_ONE;
            // Strict compare: the earliest selection keeps a tied best value.
            if (tv_q > best_value_q) begin
              best_value_d = tv_q;
              best_sel_d   = sel_q;
            end
          end else if (sol_ready_i) begin
            sol_valid_d = 1'b0;
          end
          if (&k_q) begin
            state_d = ST_DONE;
          end else begin
            k_d         = kp1;
            sel_d[flip_j] = rising;
            tv_d = rising ? tv_q + ACC_W'(coef.val) : tv_q - ACC_W'(coef.val);
            tw_d = rising ? tw_q + ACC_W'(coef.wgt) : tw_q - ACC_W'(coef.wgt);
            tu_d = rising ? tu_q + ACC_W'(coef.vol) : tu_q - ACC_W'(coef.vol);
          end
        end
      end
      default: begin
        // Last solution may still be pending when the search finishes.
        if (state_q == ST_DONE && sol_valid_q && sol_ready_i) sol_valid_d = 1'b0;
        if (start_i) begin
          state_d      = ST_RUN;
          k_d          = '0;
          sel_d        = '0;
          tv_d         = '0;
          tw_d         = '0;
          tu_d         = '0;
          sol_valid_d  = 1'b0;
          sol_sel_d    = '0;
          sol_value_d  = '0;
          best_sel_d   = '0;
          best_value_d = '0;
          sol_count_d  = '0;
        end
      end
    endcase

    if (abort_i) begin
      state_d     = ST_IDLE;
      sol_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      sel_q        <= '0;
      tv_q         <= '0;
      tw_q         <= '0;
      tu_q         <= '0;
      sol_valid_q  <= 1'b0;
      sol_sel_q    <= '0;
      sol_value_q  <= '0;
      best_sel_q   <= '0;
      best_value_q <= '0;
      sol_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      sel_q        <= sel_d;
      tv_q         <= tv_d;
      tw_q         <= tw_d;
      tu_q         <= tu_d;
      sol_valid_q  <= sol_valid_d;
      sol_sel_q    <= sol_sel_d;
      sol_value_q  <= sol_value_d;
      best_sel_q   <= best_sel_d;
      best_value_q <= best_value_d;
      sol_count_q  <= sol_count_d;
    end
  end

  // The table is only read in RUN, so an IDLE write alongside start is seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ITEMS; i++) table_q[i] <= '0;
    end else if (item_wr_i && state_q == ST_IDLE && 32'(item_idx_i) < N_ITEMS) begin
      table_q[item_idx_i] <= '{val: item_val_i, wgt: item_wgt_i, vol: item_vol_i};
    end
  end

  assign sol_valid_o  = sol_valid_q;
  assign sol_sel_o    = sol_sel_q;
  assign sol_value_o  = sol_value_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign best_sel_o   = best_sel_q;
  assign best_value_o = best_value_q;
  assign sol_count_o  = sol_count_q;

endmodule

// File: tb/tb_knap_gray_search.sv
// Self-checking bench for knap_gray_search with a 4-item problem.
// Reference model enumerates selections directly from the Gray formula
// g = k ^ (k >> 1) and sums coefficients from scratch per candidate.
module tb_knap_gray_search;

  localparam int N = 4;
  localparam int MINV = 20;
  localparam int MAXW = 60;
  localparam int MAXU = 60;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         item_wr = 1'b0;
  logic [1:0]   item_idx = '0;
  logic [4:0]   item_val = '0, item_wgt = '0, item_vol = '0;
  logic         start = 1'b0, abort = 1'b0, sol_ready = 1'b1;
  logic         sol_valid, busy, done;
  logic [N-1:0] sol_sel, best_sel;
  logic [9:0]   sol_value, best_value;
  logic [N:0]   sol_count;

  always #5 clk = ~clk;

  knap_gray_search #(
    .N_ITEMS(N), .COEF_W(5), .ACC_W(10),
    .MIN_VALUE(MINV), .MAX_WEIGHT(MAXW), .MAX_VOLUME(MAXU)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .item_wr_i(item_wr), .item_idx_i(item_idx),
    .item_val_i(item_val), .item_wgt_i(item_wgt), .item_vol_i(item_vol),
    .start_i(start), .abort_i(abort),
    .sol_valid_o(sol_valid), .sol_ready_i(sol_ready),
    .sol_sel_o(sol_sel), .sol_value_o(sol_value),
    .busy_o(busy), .done_o(done),
    .best_sel_o(best_sel), .best_value_o(best_value), .sol_count_o(sol_count)
  );

  typedef struct { int sel; int val; } sol_t;

  int   mv[N], mw[N], mu[N];
  sol_t exp_q[$];
  int   exp_best_sel, exp_best_val, exp_count;
  int   checks = 0, passes = 0;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [N-1:0] prev_sel;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: every selection in enumeration order, totals summed from scratch.
  task automatic build_model();
    exp_q.delete();
    exp_best_sel = 0;
    exp_best_val = 0;
    exp_count = 0;
    for (int k = 0; k < (1 << N); k++) begin
      int g, v, w, u;
      g = k ^ (k >> 1);
      v = 0; w = 0; u = 0;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin v += mv[i]; w += mw[i]; u += mu[i]; end
      end
      if (v >= MINV && w <= MAXW && u <= MAXU) begin
        exp_q.push_back('{sel: g, val: v});
        exp_count++;
        if (v > exp_best_val) begin exp_best_val = v; exp_best_sel = g; end
      end
    end
  endtask

  // Stream checker: each handshake must match the next model solution, and
  // a stalled output must hold still.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_hold_valid", int'(sol_valid), 1);
        chk("stall_hold_sel", int'(sol_sel), int'(prev_sel));
      end
      if (sol_valid && sol_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_solution", int'(sol_sel), -1);
        end else begin
          sol_t e;
          e = exp_q.pop_front();
          chk("stream_sel", int'(sol_sel), e.sel);
          chk("stream_value", int'(sol_value), e.val);
        end
      end
      prev_stall = sol_valid && !sol_ready;
      prev_sel   = sol_sel;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_item(input int idx, input int v, input int w, input int u);
    item_wr = 1'b1; item_idx = 2'(idx);
    item_val = 5'(v); item_wgt = 5'(w); item_vol = 5'(u);
    tick();
    item_wr = 1'b0;
  endtask

  task automatic load_table(input int v[N], input int w[N], input int u[N]);
    for (int i = 0; i < N; i++) begin
      mv[i] = v[i]; mw[i] = w[i]; mu[i] = u[i];
      write_item(i, v[i], w[i], u[i]);
    end
  endtask

  task automatic do_abort();
    mon_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("count_cleared_on_start", int'(sol_count), 0);
  endtask

  // Runs until done (bounded), optionally with random ready or a dropped write.
  task automatic run_full(input bit rnd, input bit inj, input bit chk_cyc, input string tag);
    int cyc;
    build_model();
    sol_ready = 1'b1;
    mon_en = 1'b1;
    start_pulse();
    cyc = 0;
    while (!done && cyc < 500) begin
      if (rnd) sol_ready = 1'($urandom_range(0, 1));
      item_wr = inj && (cyc == 2);
      item_idx = 2'd3; item_val = 5'd0;
      tick();
      cyc++;
    end
    item_wr = 1'b0;
    if (!done) chk({tag, "_done_timeout"}, cyc, -1);
    if (chk_cyc) chk({tag, "_cycles_to_done"}, cyc, 16);
    sol_ready = 1'b1;
    repeat (3) tick();
    mon_en = 1'b0;
    chk({tag, "_drained_valid"}, int'(sol_valid), 0);
    chk({tag, "_missing_solutions"}, exp_q.size(), 0);
    chk({tag, "_sol_count"}, int'(sol_count), exp_count);
    chk({tag, "_best_value"}, int'(best_value), exp_best_val);
    chk({tag, "_best_sel"}, int'(best_sel), exp_best_sel);
    chk({tag, "_done_held"}, int'(done), 1);
  endtask

  initial begin
    int sv[N], sw[N], su[N], zv[N];
    int cyc;
    sv = '{4, 8, 0, 20};
    sw = '{28, 8, 27, 18};
    su = '{27, 27, 4, 4};
    zv = '{0, 0, 0, 0};

    repeat (2) tick();
    chk("rst_sol_valid", int'(sol_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_best_value", int'(best_value), 0);
    chk("rst_sol_count", int'(sol_count), 0);
    rst = 1'b0;
    tick();

    load_table(sv, sw, su);
    // Hand-computed values pin the model before it is trusted.
    build_model();
    chk("model_count", exp_count, 6);
    chk("model_first_sel", exp_q[0].sel, 4'b1100);
    chk("model_fourth_val", exp_q[3].val, 32);
    chk("model_best_sel", exp_best_sel, 4'b1011);

    run_full(1'b0, 1'b0, 1'b1, "full");
    chk("full_best_literal", int'(best_value), 32);

    // Restart from DONE with the consumer stalled at the first solution.
    build_model();
    sol_ready = 1'b0;
    mon_en = 1'b1;
    start_pulse();
    cyc = 0;
    while (!sol_valid && cyc < 50) begin tick(); cyc++; end
    if (!sol_valid) chk("stall_wait_timeout", cyc, -1);
    repeat (5) tick();
    chk("stall_sel", int'(sol_sel), 4'b1100);
    chk("stall_value", int'(sol_value), 20);
    chk("stall_no_finish", int'(busy), 1);
    sol_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    if (!done) chk("stall_done_timeout", cyc, -1);
    repeat (3) tick();
    mon_en = 1'b0;
    chk("stall_missing", exp_q.size(), 0);
    chk("stall_count", int'(sol_count), 6);

    run_full(1'b1, 1'b0, 1'b0, "rndready");

    do_abort();
    load_table(zv, sw, su);
    run_full(1'b0, 1'b0, 1'b1, "zeroval");
    chk("zeroval_best_literal", int'(best_value), 0);

    do_abort();
    load_table(sv, sw, su);
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_valid", int'(sol_valid), 0);
    run_full(1'b0, 1'b0, 1'b1, "after_abort");

    do_abort();
    run_full(1'b1, 1'b1, 1'b0, "wr_in_run");
    chk("wr_in_run_best_literal", int'(best_value), 32);

    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(sol_valid), 0);
    chk("midrst_count", int'(sol_count), 0);
    chk("midrst_best_sel", int'(best_sel), 0);
    mv = zv; mw = zv; mu = zv;
    run_full(1'b0, 1'b0, 1'b1, "cleared_table");

    for (int t = 0; t < 4; t++) begin
      int rv[N], rw[N], ru[N];
      do_abort();
      for (int i = 0; i < N; i++) begin
        rv[i] = $urandom_range(0, 31);
        rw[i] = $urandom_range(0, 31);
        ru[i] = $urandom_range(0, 31);
      end
      load_table(rv, rw, ru);
      run_full(1'b1, 1'b0, 1'b0, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
